// File: rtl/datapath_seq.sv
// Upstream sequencer for Datapath: loads both operands, runs the ALU, and holds the result behind a valid/ready output.
// Optional out_flags {neg, zero} port is enabled by defining DATAPATH_SEQ_FLAGS_EN.
module datapath_seq #(
    parameter int size_data = 16,
    parameter int ms_width  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ms_width-1:0]  in_op,
    input  logic [size_data-1:0] in_a,
    input  logic [size_data-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [size_data-1:0] out_data,
    output logic                 busy,
    output logic [size_data-1:0] Din,
    output logic                 WE,
    output logic                 W1,
    output logic [ms_width-1:0]  MS,
    input  logic [size_data-1:0] ALU_out
`ifdef DATAPATH_SEQ_FLAGS_EN
    ,
    output logic [1:0]           out_flags
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [ms_width-1:0]  op_reg;
    logic [size_data-1:0] a_reg;
    logic [size_data-1:0] b_reg;
    logic [size_data-1:0] out_data_reg;
    logic                 accept;
    logic                 capture;

    // State register plus operand latch and result capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg <= in_op;
                a_reg  <= in_a;
                b_reg  <= in_b;
            end
            if (capture) begin
                out_data_reg <= ALU_out;
            end
        end
    end

    // Next-state and output decode; outputs depend only on state_reg except in_ready
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        WE         = 1'b0;
        W1         = 1'b0;
        Din        = '0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                WE         = 1'b1;
                Din        = a_reg;
                state_next = LOAD_B;
            end
            LOAD_B: begin
                WE         = 1'b1;
                W1         = 1'b1;
                Din        = b_reg;
                state_next = EXEC;
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = LOAD_A;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign MS        = op_reg;
    assign out_data  = out_data_reg;

`ifdef DATAPATH_SEQ_FLAGS_EN
    logic [1:0] flags_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_reg <= 2'b00;
        end else if (capture) begin
            flags_reg <= {ALU_out[size_data-1], (ALU_out == '0)};
        end
    end

    assign out_flags = flags_reg;
`endif

endmodule
